// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WordWidth = 32;
  localparam int unsigned AddrWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Faults on any non-word-aligned address or a word index beyond the array.
  function automatic logic addr_fault(logic [AddrWidth-1:0] addr, int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[AddrWidth-1:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                 req_valid;
  logic                 req_write;
  logic [AddrWidth-1:0] req_addr;
  logic [WordWidth-1:0] req_wdata;
  logic                 req_ready;
  logic                 resp_valid;
  logic [WordWidth-1:0] resp_rdata;
  logic                 resp_err;
  logic                 busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/dmem_storage.sv
// Word array with synchronous write and registered read; contents survive reset.
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IdxWidth    = 6
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [IdxWidth-1:0]  idx_i,
  input  logic [WordWidth-1:0] wdata_i,
  output logic [WordWidth-1:0] rdata_o
);

  logic [WordWidth-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_o <= mem_q[idx_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: one access in flight, fixed latency, fault on bad address.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IdxWidth = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntInit  = 4'(LATENCY - 1);

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic                 write_q;
  logic                 fault_q;
  logic [IdxWidth-1:0]  idx_q;
  logic [WordWidth-1:0] wdata_q;
  logic                 ready_q;
  logic                 resp_valid_q;
  logic                 busy_q;
  logic                 resp_err_q;
  logic [WordWidth-1:0] resp_rdata_q;

  logic                 commit;
  logic [IdxWidth-1:0]  st_idx;
  logic [WordWidth-1:0] st_rdata;

  assign commit = (state_q == StWait) && (cnt_q == 4'd0);

  // While idle the array is addressed straight from the request so that a LATENCY=1
  // access still has its read data registered by the commit edge.
  assign st_idx = (state_q == StIdle) ? bus.req_addr[IdxWidth+1:2] : idx_q;

  dmem_storage #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IdxWidth    (IdxWidth)
  ) u_storage (
    .clk_i   (clk),
    .we_i    (commit && write_q && !fault_q),
    .idx_i   (st_idx),
    .wdata_i (wdata_q),
    .rdata_o (st_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      fault_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            fault_q <= addr_fault(bus.req_addr, DEPTH_WORDS);
            idx_q   <= bus.req_addr[IdxWidth+1:2];
            wdata_q <= bus.req_wdata;
            cnt_q   <= CntInit;
            state_q <= StWait;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_err_q   <= fault_q;
            resp_rdata_q <= (write_q || fault_q) ? '0 : st_rdata;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q      <= StIdle;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          busy_q       <= 1'b0;
          ready_q      <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2, 1 and 3 instances on a shared clock.
module tb_dmem_responder;

  typedef struct {
    logic        write;
    logic        fault;
    int unsigned idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic        drv_valid [3];
  logic        drv_write [3];
  logic [31:0] drv_addr  [3];
  logic [31:0] drv_wdata [3];
  logic        ob_ready  [3];
  logic        ob_rvalid [3];
  logic [31:0] ob_rdata  [3];
  logic        ob_err    [3];
  logic        ob_busy   [3];

  exp_t        sb [3][$];
  logic [31:0] model [3][64];
  int          lat [3];
  int          acc_cnt [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst),  .bus(bus0));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst),  .bus(bus1));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(3)) u_dut2 (.clk(clk), .rst(rst3), .bus(bus2));

  assign bus0.req_valid = drv_valid[0];
  assign bus0.req_write = drv_write[0];
  assign bus0.req_addr  = drv_addr[0];
  assign bus0.req_wdata = drv_wdata[0];
  assign bus1.req_valid = drv_valid[1];
  assign bus1.req_write = drv_write[1];
  assign bus1.req_addr  = drv_addr[1];
  assign bus1.req_wdata = drv_wdata[1];
  assign bus2.req_valid = drv_valid[2];
  assign bus2.req_write = drv_write[2];
  assign bus2.req_addr  = drv_addr[2];
  assign bus2.req_wdata = drv_wdata[2];

  assign ob_ready[0]  = bus0.req_ready;
  assign ob_rvalid[0] = bus0.resp_valid;
  assign ob_rdata[0]  = bus0.resp_rdata;
  assign ob_err[0]    = bus0.resp_err;
  assign ob_busy[0]   = bus0.busy;
  assign ob_ready[1]  = bus1.req_ready;
  assign ob_rvalid[1] = bus1.resp_valid;
  assign ob_rdata[1]  = bus1.resp_rdata;
  assign ob_err[1]    = bus1.resp_err;
  assign ob_busy[1]   = bus1.busy;
  assign ob_ready[2]  = bus2.req_ready;
  assign ob_rvalid[2] = bus2.resp_valid;
  assign ob_rdata[2]  = bus2.resp_rdata;
  assign ob_err[2]    = bus2.resp_err;
  assign ob_busy[2]   = bus2.busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Responses are popped before acceptances are pushed so a back-to-back load sees the
  // store that completed on the same sample.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ob_rvalid[d]) begin
        if (sb[d].size() == 0) begin
          check("unexpected_resp", 32'(ob_rvalid[d]), 32'd0);
        end else begin
          e = sb[d].pop_front();
          check("resp_rdata", ob_rdata[d], e.rdata);
          check("resp_err", 32'(ob_err[d]), 32'(e.fault));
          check("resp_latency", 32'(cyc - e.acc_cyc), 32'(lat[d] + 1));
          if (e.write && !e.fault) model[d][e.idx] = e.wdata;
        end
      end
      if (drv_valid[d] && ob_ready[d]) begin
        e.write   = drv_write[d];
        e.fault   = (drv_addr[d][1:0] != 2'b00) || (drv_addr[d] >= 32'd256);
        e.idx     = int'(drv_addr[d][7:2]);
        e.wdata   = drv_wdata[d];
        e.rdata   = (e.write || e.fault) ? 32'd0 : model[d][e.idx];
        e.acc_cyc = cyc;
        sb[d].push_back(e);
        acc_cnt[d]++;
      end
    end
  end

  task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n_lo;
    int n_busy;
    bit ok;
    @(posedge clk);
    #1;
    drv_valid[d] = 1'b1;
    drv_write[d] = wr;
    drv_addr[d]  = addr;
    drv_wdata[d] = wdata;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ob_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    check("accepted", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    drv_valid[d] = 1'b0;
    n_lo   = 0;
    n_busy = 0;
    ok     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ob_ready[d]) begin
        ok = 1'b1;
        break;
      end
      n_lo++;
      if (ob_busy[d]) n_busy++;
    end
    check("ready_returned", 32'(ok), 32'd1);
    check("ready_low_cycles", 32'(n_lo), 32'(lat[d] + 1));
    check("busy_cycles", 32'(n_busy), 32'(lat[d] + 1));
  endtask

  task automatic drain(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ob_ready[d] && !ob_busy[d] && sb[d].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drained", 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int n;
    lat = '{2, 1, 3};
    for (int d = 0; d < 3; d++) begin
      drv_valid[d] = 1'b0;
      drv_write[d] = 1'b0;
      drv_addr[d]  = 32'd0;
      drv_wdata[d] = 32'd0;
      acc_cnt[d]   = 0;
      for (int w = 0; w < 64; w++) model[d][w] = 32'd0;
    end
    rst  = 1'b1;
    rst3 = 1'b1;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_req_ready", 32'(ob_ready[d]), 32'd1);
      check("rst_resp_valid", 32'(ob_rvalid[d]), 32'd0);
      check("rst_resp_rdata", ob_rdata[d], 32'd0);
      check("rst_resp_err", 32'(ob_err[d]), 32'd0);
      check("rst_busy", 32'(ob_busy[d]), 32'd0);
    end

    // LATENCY=2: store/load, faults, out-of-range store leaves words 0 and 63 alone
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_req(0, 1'b0, 32'h10, 32'h0);
    do_req(0, 1'b1, 32'h00, 32'hA5A5A5A5);
    do_req(0, 1'b1, 32'hFC, 32'h5A5A0063);
    do_req(0, 1'b0, 32'h13, 32'h0);
    do_req(0, 1'b0, 32'h100, 32'h0);
    do_req(0, 1'b1, 32'h100, 32'hFFFFFFFF);
    do_req(0, 1'b1, 32'h12, 32'hFFFFFFFF);
    do_req(0, 1'b0, 32'h00, 32'h0);
    do_req(0, 1'b0, 32'hFC, 32'h0);
    do_req(0, 1'b0, 32'h10, 32'h0);

    // Held request: accepted at edges 0, 4, 8 of a 12-edge window (idle, wait x2, resp).
    @(posedge clk);
    #1;
    a = acc_cnt[0];
    drv_valid[0] = 1'b1;
    drv_write[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drv_addr[0] = i[0] ? 32'h10 : 32'h00;
      @(posedge clk);
      #1;
    end
    drv_valid[0] = 1'b0;
    check("held_accepts_lat2", 32'(acc_cnt[0] - a), 32'd3);
    drain(0);

    // LATENCY=1: store then load of the same word at minimum spacing (edges 0 and 3).
    @(posedge clk);
    #1;
    a = acc_cnt[1];
    drv_valid[1] = 1'b1;
    drv_write[1] = 1'b1;
    drv_addr[1]  = 32'h24;
    drv_wdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    drv_write[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drv_valid[1] = 1'b0;
    check("held_accepts_lat1", 32'(acc_cnt[1] - a), 32'd2);
    drain(1);
    do_req(1, 1'b0, 32'h24, 32'h0);

    // LATENCY=3: reset one cycle after accepting a store must abort it cleanly.
    do_req(2, 1'b1, 32'h20, 32'h11111111);
    @(posedge clk);
    #1;
    drv_valid[2] = 1'b1;
    drv_write[2] = 1'b1;
    drv_addr[2]  = 32'h20;
    drv_wdata[2] = 32'h12345678;
    @(negedge clk);
    check("abort_ready_before", 32'(ob_ready[2]), 32'd1);
    @(posedge clk);
    #1;
    drv_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    rst3 = 1'b1;
    #1;
    check("abort_req_ready", 32'(ob_ready[2]), 32'd1);
    check("abort_busy", 32'(ob_busy[2]), 32'd0);
    check("abort_resp_valid", 32'(ob_rvalid[2]), 32'd0);
    check("abort_resp_rdata", ob_rdata[2], 32'd0);
    check("abort_resp_err", 32'(ob_err[2]), 32'd0);
    sb[2].delete();
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ob_rvalid[2]) n++;
    end
    check("abort_no_resp", 32'(n), 32'd0);
    do_req(2, 1'b0, 32'h20, 32'h0);
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
